// File: rtl/bmp_stream_encoder.sv
// bmp_stream_encoder
//   Frames a live vsync/de video stream into a complete top-down BMP file byte
//   stream: 54-byte header, pixel rows (B,G,R[,0x00]) and row padding.
//   A small pixel FIFO absorbs output back-pressure. No frame buffer is needed
//   because the header declares a negative height (rows stored top-down).
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_vsync        frame sync, rising edge starts a frame
//   i_hsync        line sync, informational only
//   i_de, i_data   pixel valid / pixel {R,G,B}
//   o_valid, i_ready, o_byte   byte stream handshake
//   o_sof, o_eof   first header byte / last byte of frame markers
//   o_busy         frame in progress (frame start until eof transfer)
//   o_overflow     sticky pixel-drop flag, cleared at frame start
//   o_frame_err    one-cycle pulse when a frame is truncated by a new vsync
module bmp_stream_encoder #(
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int BPP        = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int PPM        = 2835
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_vsync,
  input  logic        i_hsync,
  input  logic        i_de,
  input  logic [23:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_byte,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_frame_err
);

  if (!(BPP == 24 || BPP == 32)) begin : g_bad_bpp
    $error("bmp_stream_encoder: BPP must be 24 or 32");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bmp_stream_encoder: FIFO_DEPTH must be a power of 2 and >= 4");
  end

  localparam int BYTES = BPP / 8;
  localparam int PAD   = (4 - (HRES * BYTES) % 4) % 4;
  localparam int IMG   = (HRES * BYTES + PAD) * VRES;
  localparam int FSIZE = 54 + IMG;
  localparam int PW    = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int RW    = (VRES > 1) ? $clog2(VRES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  function automatic logic [31:0] le32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [15:0] le16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // Header ROM, byte 0 in the most significant position.
  localparam logic [431:0] HDR_ROM = {
    8'h42, 8'h4D, le32(32'(FSIZE)), le16(16'h0000), le16(16'h0000),
    le32(32'd54), le32(32'd40), le32(32'(HRES)), le32(32'(-VRES)),
    le16(16'h0001), le16(16'(BPP)), le32(32'h0), le32(32'(IMG)),
    le32(32'(PPM)), le32(32'(PPM)), le32(32'h0), le32(32'h0)};

  localparam logic [1:0]    LAST_BYTE = 2'(BYTES - 1);
  localparam logic [1:0]    LAST_PAD  = 2'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [PW-1:0] LAST_PIX  = PW'(HRES - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(VRES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_PIXEL, ST_PAD, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [5:0]      hdr_q, hdr_d;
  logic [1:0]      byte_q, byte_d;        // byte within pixel, reused as pad counter
  logic [PW-1:0]   pix_q, pix_d;
  logic [RW-1:0]   row_q, row_d;
  logic            vsync_q, busy_q, ovf_q, ferr_q;
  logic            busy_d, ovf_d, ferr_d;
  logic            out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [23:0]     mem_q [FIFO_DEPTH];

  logic            rise_s, xfer_s, eof_xfer_s, load_s;
  logic            fifo_empty_s, fifo_full_s, push_s, drop_s, pop_s;
  logic            cand_valid_s, cand_eof_s;
  logic [7:0]      cand_byte_s;
  logic [23:0]     head_s;
  logic            hsync_unused;

  assign hsync_unused = i_hsync;

  assign rise_s       = i_vsync & ~vsync_q;
  assign xfer_s       = out_valid_q & i_ready;
  assign eof_xfer_s   = xfer_s & out_eof_q;
  // The output register can take a new byte when empty or draining this cycle.
  assign load_s       = ~out_valid_q | i_ready;
  assign fifo_empty_s = (wr_q == rd_q);
  assign fifo_full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_s       = mem_q[rd_q[AW-1:0]];
  // A pop in the same cycle frees a slot, so a push into a full FIFO is not a drop.
  assign push_s       = i_de & busy_q & (~fifo_full_s | pop_s) & ~rise_s;
  assign drop_s       = i_de & busy_q & fifo_full_s & ~pop_s & ~rise_s;

  // Framing FSM: produces the next candidate byte and advances when it is loaded.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    byte_d       = byte_q;
    pix_d        = pix_q;
    row_d        = row_q;
    cand_valid_s = 1'b0;
    cand_byte_s  = 8'h00;
    cand_eof_s   = 1'b0;
    pop_s        = 1'b0;
    case (state_q)
      ST_HEADER: begin
        cand_valid_s = 1'b1;
        cand_byte_s  = HDR_ROM[{6'd53 - hdr_q, 3'b000} +: 8];
        if (load_s) begin
          if (hdr_q == 6'd53) begin
            state_d = ST_PIXEL;
            byte_d  = 2'd0;
            pix_d   = '0;
            row_d   = '0;
          end else begin
            hdr_d = hdr_q + 6'd1;
          end
        end else begin
          hdr_d = hdr_q;
        end
      end
      ST_PIXEL: begin
        cand_valid_s = ~fifo_empty_s;
        case (byte_q)
          2'd0:    cand_byte_s = head_s[7:0];
          2'd1:    cand_byte_s = head_s[15:8];
          2'd2:    cand_byte_s = head_s[23:16];
          default: cand_byte_s = 8'h00;
        endcase
        cand_eof_s = (byte_q == LAST_BYTE) && (pix_q == LAST_PIX) &&
                     (row_q == LAST_ROW) && (PAD == 0);
        if (load_s && !fifo_empty_s) begin
          if (byte_q == LAST_BYTE) begin
            pop_s  = 1'b1;
            byte_d = 2'd0;
            if (pix_q == LAST_PIX) begin
              pix_d = '0;
              if (PAD != 0) begin
                state_d = ST_PAD;
              end else if (row_q == LAST_ROW) begin
                state_d = ST_DONE;
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              pix_d = pix_q + PW'(1);
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_PAD: begin
        cand_valid_s = 1'b1;
        cand_eof_s   = (byte_q == LAST_PAD) && (row_q == LAST_ROW);
        if (load_s) begin
          if (byte_q == LAST_PAD) begin
            byte_d = 2'd0;
            if (row_q == LAST_ROW) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = ST_PIXEL;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end else begin
          byte_d = byte_q;
        end
      end
      ST_DONE: begin
        if (eof_xfer_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Frame start (or abort) wins: header byte 0 goes straight to the output.
    if (rise_s) begin
      state_d = ST_HEADER;
      hdr_d   = 6'd1;
      byte_d  = 2'd0;
      pix_d   = '0;
      row_d   = '0;
      pop_s   = 1'b0;
    end else begin
      hdr_d = hdr_d;
    end
  end

  // Output register next state: hold while stalled, reload or drain otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    if (rise_s) begin
      out_valid_d = 1'b1;
      out_byte_d  = 8'h42;
      out_sof_d   = 1'b1;
      out_eof_d   = 1'b0;
    end else if (load_s && cand_valid_s) begin
      out_valid_d = 1'b1;
      out_byte_d  = cand_byte_s;
      out_sof_d   = 1'b0;
      out_eof_d   = cand_eof_s;
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
      out_byte_d  = 8'h00;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Status flags and FIFO pointers next state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    ovf_d  = rise_s ? 1'b0 : (ovf_q | drop_s);
    // An eof transfer coinciding with the new vsync is a clean frame end.
    ferr_d = rise_s & busy_q & ~eof_xfer_s;
    wr_d   = rise_s ? '0 : wr_q + {{AW{1'b0}}, push_s};
    rd_d   = rise_s ? '0 : rd_q + {{AW{1'b0}}, pop_s};
  end

  // State, counter, flag and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= 6'd0;
      byte_q      <= 2'd0;
      pix_q       <= '0;
      row_q       <= '0;
      vsync_q     <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      byte_q      <= byte_d;
      pix_q       <= pix_d;
      row_q       <= row_d;
      vsync_q     <= i_vsync;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  // Pixel FIFO storage (contents need no reset; pointers define validity).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= i_data;
    end
  end

  assign o_valid     = out_valid_q;
  assign o_byte      = out_byte_q;
  assign o_sof       = out_sof_q;
  assign o_eof       = out_eof_q;
  assign o_busy      = busy_q;
  assign o_overflow  = ovf_q;
  assign o_frame_err = ferr_q;

endmodule
